// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - LC-3 ADD/AND/NOT sequencer with internal regfile; ALU_SEQ_PERF_EN adds perf counters
module alu_instr_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      instr_valid,
  input  logic [15:0]               instr,
  output logic                      instr_ready,
  input  logic                      host_we,
  input  logic [$clog2(NREGS)-1:0]  host_addr,
  input  logic [DATA_W-1:0]         host_data,
  input  logic [$clog2(NREGS)-1:0]  dbg_sel,
  output logic [DATA_W-1:0]         dbg_data,
  output logic [1:0]                ALUK,
  output logic                      SR2MUX,
  output logic [15:0]               ALU_IR,
  output logic [DATA_W-1:0]         ALU_A,
  output logic [DATA_W-1:0]         ALU_B,
  input  logic [DATA_W-1:0]         ALU_OUT,
  output logic [2:0]                NZP,
  output logic                      done,
  output logic                      illegal
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]               perf_ops,
  output logic [7:0]                perf_ill
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WB,
    S_ILL
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] result;

  logic [3:0] opcode;
  logic       is_add, is_and, is_not, legal;
  logic [1:0] aluk_dec;
  logic       sr2mux_dec;
  logic [2:0] dr, sr1, sr2;

  assign opcode = ALU_IR[15:12];
  assign dr     = ALU_IR[11:9];
  assign sr1    = ALU_IR[8:6];
  assign sr2    = ALU_IR[2:0];

  assign is_add = (opcode == 4'b0001);
  assign is_and = (opcode == 4'b0101);
  assign is_not = (opcode == 4'b1001);

  // register-mode ADD/AND must have IR[4:3]=00; NOT must carry the all-ones tail
  assign legal = ((is_add || is_and) && (ALU_IR[5] || (ALU_IR[4:3] == 2'b00)))
               || (is_not && (ALU_IR[5:0] == 6'h3F));

  assign aluk_dec   = is_and ? 2'b01 : (is_not ? 2'b11 : 2'b00);
  assign sr2mux_dec = (is_add || is_and) && ALU_IR[5];

  assign dbg_data = regs[dbg_sel];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = Reset_n && !host_we;
        if (!host_we && instr_valid) begin
          state_n = S_DECODE;
        end
      end
      S_DECODE: state_n = legal ? S_READ : S_ILL;
      S_READ:   state_n = S_EXEC;
      S_EXEC:   state_n = S_WB;
      S_WB: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      S_ILL: begin
        illegal = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ALU_IR <= '0;
      ALUK   <= '0;
      SR2MUX <= 1'b0;
      ALU_A  <= '0;
      ALU_B  <= '0;
      result <= '0;
      NZP    <= 3'b010;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          // host writes take priority; the instruction waits for the next cycle
          if (host_we) begin
            regs[host_addr] <= host_data;
          end else if (instr_valid) begin
            ALU_IR <= instr;
          end
        end
        S_DECODE: begin
          if (legal) begin
            ALUK   <= aluk_dec;
            SR2MUX <= sr2mux_dec;
          end
        end
        S_READ: begin
          ALU_A <= regs[sr1];
          ALU_B <= regs[sr2];
        end
        S_EXEC: result <= ALU_OUT;
        S_WB: begin
          regs[dr] <= result;
          if (result[DATA_W-1]) begin
            NZP <= 3'b100;
          end else if (result == '0) begin
            NZP <= 3'b010;
          end else begin
            NZP <= 3'b001;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      perf_ops <= '0;
      perf_ill <= '0;
    end else begin
      if (done && (perf_ops != 16'hFFFF)) begin
        perf_ops <= perf_ops + 16'd1;
      end
      if (illegal && (perf_ill != 8'hFF)) begin
        perf_ill <= perf_ill + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - self-checking bench for alu_instr_sequencer with transaction-level model
module tb_alu_instr_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_ready;
  logic        host_we = 1'b0;
  logic [2:0]  host_addr = 3'd0;
  logic [15:0] host_data = 16'h0000;
  logic [2:0]  dbg_sel = 3'd0;
  logic [15:0] dbg_data;
  logic [1:0]  ALUK;
  logic        SR2MUX;
  logic [15:0] ALU_IR, ALU_A, ALU_B, ALU_OUT;
  logic [2:0]  NZP;
  logic        done, illegal;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_ops;
  logic [7:0]  perf_ill;
`endif

  always #5 Clk = ~Clk;

  alu_instr_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .ALUK(ALUK), .SR2MUX(SR2MUX), .ALU_IR(ALU_IR), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_OUT(ALU_OUT), .NZP(NZP), .done(done), .illegal(illegal)
`ifdef ALU_SEQ_PERF_EN
    , .perf_ops(perf_ops), .perf_ill(perf_ill)
`endif
  );

  // the combinational LC-3 ALU the sequencer drives
  logic [15:0] alu_op2;
  always_comb begin
    alu_op2 = SR2MUX ? {{11{ALU_IR[4]}}, ALU_IR[4:0]} : ALU_B;
    case (ALUK)
      2'b00:   ALU_OUT = ALU_A + alu_op2;
      2'b01:   ALU_OUT = ALU_A & alu_op2;
      2'b11:   ALU_OUT = ~ALU_A;
      default: ALU_OUT = 16'h0000;
    endcase
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // model: architectural state plus the cycle at which each pending event lands
  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;
  logic [15:0] m_ir;
  logic [15:0] p_res;
  logic [2:0]  p_dr;
  int t_done, t_ill, t_free;
  int m_ops, m_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_nzp = 3'b010; m_ir = 16'h0000;
    t_done = -1; t_ill = -1; t_free = 0;
    m_ops = 0; m_ill = 0;
  endtask

  task automatic model_accept(input logic [15:0] w);
    logic [15:0] a, b;
    logic ok;
    m_ir = w;
    a = m_regs[w[8:6]];
    b = w[5] ? {{11{w[4]}}, w[4:0]} : m_regs[w[2:0]];
    ok = 1'b0;
    p_res = 16'h0000;
    case (w[15:12])
      4'h1: begin ok = w[5] || (w[4:3] == 2'b00); p_res = a + b; end
      4'h5: begin ok = w[5] || (w[4:3] == 2'b00); p_res = a & b; end
      4'h9: begin ok = (w[5:0] == 6'h3F); p_res = ~a; end
      default: ok = 1'b0;
    endcase
    p_dr = w[11:9];
    if (ok) begin t_done = cyc + 4; t_free = cyc + 5; end
    else    begin t_ill  = cyc + 2; t_free = cyc + 3; end
  endtask

  initial model_reset();

  always @(negedge Clk) begin
    if (!Reset_n) model_reset();
    chk("instr_ready", instr_ready, Reset_n && (cyc >= t_free) && !host_we);
    chk("done", done, Reset_n && (cyc == t_done));
    chk("illegal", illegal, Reset_n && (cyc == t_ill));
    chk("nzp", NZP, m_nzp);
    chk("dbg_data", dbg_data, m_regs[dbg_sel]);
    chk("alu_ir", ALU_IR, m_ir);
`ifdef ALU_SEQ_PERF_EN
    chk("perf_ops", perf_ops, m_ops);
    chk("perf_ill", perf_ill, m_ill);
`endif
    if (Reset_n) begin
      if (cyc == t_done) begin
        m_regs[p_dr] = p_res;
        m_nzp = nzp_of(p_res);
        if (m_ops < 65535) m_ops++;
      end
      if (cyc == t_ill && m_ill < 255) m_ill++;
      if (cyc >= t_free) begin
        if (host_we) m_regs[host_addr] = host_data;
        else if (instr_valid) model_accept(instr);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_neg();
    @(negedge Clk);
    #1;
  endtask

  task automatic hostwr(input logic [2:0] a, input logic [15:0] d);
    host_we = 1'b1; host_addr = a; host_data = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic issue(input logic [15:0] w);
    instr_valid = 1'b1; instr = w;
    tick();
    instr_valid = 1'b0; instr = 16'($urandom);
  endtask

  task automatic peek_reg(input logic [2:0] a, input logic [15:0] lit, input string name);
    dbg_sel = a;
    wait_neg();
    chk(name, dbg_data, lit);
    chk({name, "_model"}, m_regs[a], lit);
  endtask

  task automatic peek_nzp(input logic [2:0] lit, input string name);
    chk(name, NZP, lit);
    chk({name, "_model"}, m_nzp, lit);
  endtask

  function automatic logic [15:0] gen_instr();
    logic [15:0] w;
    int k;
    w = 16'($urandom);
    k = $urandom_range(0, 6);
    if (k <= 1) begin
      w[15:12] = 4'h1;
      if (k == 0) w[5:3] = 3'b000; else w[5] = 1'b1;
    end else if (k <= 3) begin
      w[15:12] = 4'h5;
      if (k == 2) w[5:3] = 3'b000; else w[5] = 1'b1;
    end else if (k == 4) begin
      w[15:12] = 4'h9;
      w[5:0] = 6'h3F;
    end
    return w;
  endfunction

  initial begin
    #1 Reset_n = 1'b0;
    repeat (3) tick();
    Reset_n = 1'b1;
    wait_neg();
    chk("rst_ready", instr_ready, 1'b1);
    peek_nzp(3'b010, "rst_nzp");
    tick();

    // ADD R0,R1,R2 with done four cycles after the handshake
    hostwr(3'd1, 16'h0005);
    hostwr(3'd2, 16'h0003);
    issue(16'h1042);
    repeat (3) tick();
    wait_neg();
    chk("t1_done_c4", done, 1'b1);
    tick();
    peek_reg(3'd0, 16'h0008, "t1_r0");
    peek_nzp(3'b001, "t1_nzp");
    tick();

    // AND with negative immediate, then NOT
    hostwr(3'd1, 16'h00F0);
    issue(16'h5271);
    repeat (5) tick();
    peek_reg(3'd1, 16'h00F0, "t2_and_r1");
    peek_nzp(3'b001, "t2_and_nzp");
    tick();
    issue(16'h927F);
    repeat (5) tick();
    peek_reg(3'd1, 16'hFF0F, "t2_not_r1");
    peek_nzp(3'b100, "t2_not_nzp");
    tick();

    // wrap to zero
    hostwr(3'd3, 16'hFFFF);
    issue(16'h16E1);
    repeat (5) tick();
    peek_reg(3'd3, 16'h0000, "t3_r3");
    peek_nzp(3'b010, "t3_nzp");
    tick();

    // two rejected words
    issue(16'h0000);
    tick();
    wait_neg();
    chk("t4a_illegal_c2", illegal, 1'b1);
    chk("t4a_no_done", done, 1'b0);
    tick();
    issue(16'h9278);
    tick();
    wait_neg();
    chk("t4b_illegal_c2", illegal, 1'b1);
    repeat (2) tick();
    peek_reg(3'd1, 16'hFF0F, "t4_r1");
    peek_nzp(3'b010, "t4_nzp");
    tick();

    // host write collides with an offered instruction
    host_we = 1'b1; host_addr = 3'd5; host_data = 16'h1234;
    instr_valid = 1'b1; instr = 16'h1B62;
    wait_neg();
    chk("t5_ready_blocked", instr_ready, 1'b0);
    tick();
    host_we = 1'b0;
    wait_neg();
    chk("t5_ready_next", instr_ready, 1'b1);
    tick();
    instr_valid = 1'b0;
    repeat (5) tick();
    peek_reg(3'd5, 16'h1236, "t5_r5");
    peek_nzp(3'b001, "t5_nzp");
    tick();

    // reset during EXEC
    issue(16'h1042);
    repeat (2) tick();
    Reset_n = 1'b0;
    wait_neg();
    chk("t6_no_done", done, 1'b0);
    tick();
    Reset_n = 1'b1;
    wait_neg();
    chk("t6_ready", instr_ready, 1'b1);
    peek_nzp(3'b010, "t6_nzp");
    peek_reg(3'd1, 16'h0000, "t6_r1");
    peek_reg(3'd0, 16'h0000, "t6_r0");
`ifdef ALU_SEQ_PERF_EN
    chk("t6_perf_ops", perf_ops, 16'h0000);
    chk("t6_perf_ill", perf_ill, 8'h00);
`endif
    tick();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        Reset_n = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
      end
      host_we   = ($urandom_range(0, 5) == 0);
      host_addr = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       host_data = 16'h0000;
        1:       host_data = 16'hFFFF;
        2:       host_data = 16'h8000;
        default: host_data = 16'($urandom);
      endcase
      instr_valid = 1'($urandom_range(0, 1));
      instr       = gen_instr();
      dbg_sel     = 3'($urandom);
      tick();
    end

    host_we = 1'b0;
    instr_valid = 1'b0;
    repeat (8) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
